// File: rtl/video_timing_pkg.sv
// Shared timing types and the stock VGA 640x480@60 raster for the framebuffer scan-out.
package video_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_axis_t;

  localparam timing_axis_t VGA_640X480_60_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam timing_axis_t VGA_640X480_60_V = '{active: 480, fp: 10, sync: 2,  bp: 33};

  function automatic int axis_total(timing_axis_t a);
    return a.active + a.fp + a.sync + a.bp;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: wrapping counter with blank/sync decode registered from the next count,
// so blank and sync always describe the count they are presented alongside.
module video_timing_axis import video_timing_pkg::*; #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int W      = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_next,
  output logic         o_wrap,
  output logic         o_blank,
  output logic         o_sync
);

  localparam timing_axis_t AX = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
  localparam int TOTAL = axis_total(AX);
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_C   = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] r_cnt;
  logic         r_blank;
  logic         r_sync;
  logic [W-1:0] w_next;

  assign o_wrap = i_en && (r_cnt == LAST);
  assign w_next = i_en ? ((r_cnt == LAST) ? '0 : r_cnt + W'(1)) : r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_blank <= 1'b0;
      r_sync  <= ~POL;
    end else begin
      r_cnt   <= w_next;
      r_blank <= (w_next >= ACT_C);
      r_sync  <= ((w_next >= SYNC_LO) && (w_next < SYNC_HI)) ? POL : ~POL;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_next  = w_next;
  assign o_blank = r_blank;
  assign o_sync  = r_sync;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing, downscaled framebuffer scan address, tear-free buffer swap and frame IRQ.
module video_timing_gen import video_timing_pkg::*; #(
  parameter int H_ACTIVE   = VGA_640X480_60_H.active,
  parameter int H_FP       = VGA_640X480_60_H.fp,
  parameter int H_SYNC     = VGA_640X480_60_H.sync,
  parameter int H_BP       = VGA_640X480_60_H.bp,
  parameter int V_ACTIVE   = VGA_640X480_60_V.active,
  parameter int V_FP       = VGA_640X480_60_V.fp,
  parameter int V_SYNC     = VGA_640X480_60_V.sync,
  parameter int V_BP       = VGA_640X480_60_V.bp,
  parameter int SCALE_LOG2 = 2,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  localparam timing_axis_t H_AX = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP},
  localparam timing_axis_t V_AX = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP},
  localparam int H_TOTAL = axis_total(H_AX),
  localparam int V_TOTAL = axis_total(V_AX),
  localparam int CW      = $clog2(H_TOTAL),
  localparam int RW      = $clog2(V_TOTAL),
  localparam int CAW     = $clog2(H_ACTIVE >> SCALE_LOG2),
  localparam int RAW     = $clog2(V_ACTIVE >> SCALE_LOG2),
  localparam int ADDR_W  = CAW + RAW
) (
  input  logic              i_px_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_swap_req,
  input  logic              i_irq_enable,
  input  logic              i_irq_ack,
  output logic [CW-1:0]     o_col,
  output logic [RW-1:0]     o_row,
  output logic              o_hblank,
  output logic              o_vblank,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic [ADDR_W-1:0] o_pixel_addr,
  output logic              o_buf_sel,
  output logic              o_swap_pending,
  output logic              o_irq_n,
  output logic [7:0]        o_frame_count
);

  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_axis
    $error("video_timing_gen: every active/porch/sync width must be positive");
  end
  if ((H_ACTIVE % (1 << SCALE_LOG2)) != 0 || (V_ACTIVE % (1 << SCALE_LOG2)) != 0) begin : g_bad_scale
    $error("video_timing_gen: active area must be a multiple of the replication factor");
  end

  localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
  localparam logic [RW-1:0] V_ACT_C    = RW'(V_ACTIVE);
  localparam logic [RW-1:0] V_LAST_ACT = RW'(V_ACTIVE - 1);

  logic [CW-1:0]     w_h_next;
  logic [RW-1:0]     w_v_next;
  logic              w_h_wrap;
  logic              w_unused_v_wrap;
  logic              w_ve;
  logic              w_active_next;
  logic [ADDR_W-1:0] r_pixel_addr;
  logic              r_buf_sel;
  logic              r_swap_pending;
  logic              r_irq_flag;
  logic [7:0]        r_frame_count;

  video_timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL), .W(CW)
  ) u_h_axis (
    .i_clk(i_px_clock), .i_rst(i_reset), .i_en(i_enable),
    .o_cnt(o_col), .o_next(w_h_next), .o_wrap(w_h_wrap),
    .o_blank(o_hblank), .o_sync(o_hsync)
  );

  video_timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL), .W(RW)
  ) u_v_axis (
    .i_clk(i_px_clock), .i_rst(i_reset), .i_en(w_h_wrap),
    .o_cnt(o_row), .o_next(w_v_next), .o_wrap(w_unused_v_wrap),
    .o_blank(o_vblank), .o_sync(o_vsync)
  );

  // VBlank entry: the line wrap that takes the last visible row into the first blank row.
  assign w_ve          = w_h_wrap && (o_row == V_LAST_ACT);
  assign w_active_next = (w_h_next < H_ACT_C) && (w_v_next < V_ACT_C);

  always_ff @(posedge i_px_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pixel_addr   <= '0;
      r_buf_sel      <= 1'b0;
      r_swap_pending <= 1'b0;
      r_irq_flag     <= 1'b0;
      r_frame_count  <= 8'd0;
    end else begin
      r_pixel_addr <= w_active_next
        ? {w_v_next[RAW+SCALE_LOG2-1:SCALE_LOG2], w_h_next[CAW+SCALE_LOG2-1:SCALE_LOG2]}
        : '0;
      if (w_ve) begin
        if (r_swap_pending || i_swap_req) r_buf_sel <= ~r_buf_sel;
        r_swap_pending <= 1'b0;
        r_irq_flag     <= 1'b1;
        r_frame_count  <= r_frame_count + 8'd1;
      end else begin
        if (i_swap_req) r_swap_pending <= 1'b1;
        if (i_irq_ack)  r_irq_flag     <= 1'b0;
      end
    end
  end

  assign o_pixel_addr   = r_pixel_addr;
  assign o_buf_sel      = r_buf_sel;
  assign o_swap_pending = r_swap_pending;
  assign o_irq_n        = ~(r_irq_flag & i_irq_enable);
  assign o_frame_count  = r_frame_count;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 instance for line timing/addressing/freeze/reset,
// tiny 12x8 instance for frame-level swap, IRQ and frame counting.
module tb_video_timing_gen;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        rst, en, swap, irq_en, ack;
  logic [9:0]  col, row;
  logic        hblank, vblank, hsync, vsync, buf_sel, pending, irq_n;
  logic [14:0] addr;
  logic [7:0]  frame;

  // small instance: H 4/2/4/2, V 4/1/2/1, SCALE_LOG2=1, HSYNC_POL=1
  logic        s_rst, s_en, s_swap, s_irq_en, s_ack;
  logic [3:0]  s_col;
  logic [2:0]  s_row;
  logic        s_hblank, s_vblank, s_hsync, s_vsync, s_buf_sel, s_pending, s_irq_n;
  logic [1:0]  s_addr;
  logic [7:0]  s_frame;

  int n_cmp = 0;
  int n_bad = 0;
  int k_sm  = 0;

  video_timing_gen u_vga (
    .i_px_clock(clk), .i_reset(rst), .i_enable(en), .i_swap_req(swap),
    .i_irq_enable(irq_en), .i_irq_ack(ack),
    .o_col(col), .o_row(row), .o_hblank(hblank), .o_vblank(vblank),
    .o_hsync(hsync), .o_vsync(vsync), .o_pixel_addr(addr), .o_buf_sel(buf_sel),
    .o_swap_pending(pending), .o_irq_n(irq_n), .o_frame_count(frame)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SCALE_LOG2(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u_sm (
    .i_px_clock(clk), .i_reset(s_rst), .i_enable(s_en), .i_swap_req(s_swap),
    .i_irq_enable(s_irq_en), .i_irq_ack(s_ack),
    .o_col(s_col), .o_row(s_row), .o_hblank(s_hblank), .o_vblank(s_vblank),
    .o_hsync(s_hsync), .o_vsync(s_vsync), .o_pixel_addr(s_addr), .o_buf_sel(s_buf_sel),
    .o_swap_pending(s_pending), .o_irq_n(s_irq_n), .o_frame_count(s_frame)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      k_sm++;
    end
  endtask

  task automatic sm_reset();
    s_rst = 1'b1;
    tick(2);
    s_rst = 1'b0;
    k_sm  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; swap = 1'b0; irq_en = 1'b1; ack = 1'b0;
    s_rst = 1'b1; s_en = 1'b1; s_swap = 1'b0; s_irq_en = 1'b0; s_ack = 1'b0;
    tick(3);
    n_cmp++;
    if ({col, row} !== 20'd0) begin
      $display("FAIL reset_pos: got col=%0d row=%0d, need 0 0", col, row); n_bad++;
    end
    n_cmp++;
    if ({hblank, vblank, hsync, vsync} !== 4'b0011) begin
      $display("FAIL reset_blank_sync: got %b, need 0011", {hblank, vblank, hsync, vsync}); n_bad++;
    end
    n_cmp++;
    if (addr !== 15'd0) begin
      $display("FAIL reset_addr: got %h, need 0000", addr); n_bad++;
    end
    n_cmp++;
    if ({buf_sel, pending, irq_n, frame} !== {3'b001, 8'd0}) begin
      $display("FAIL reset_ctrl: got buf=%b pend=%b irq_n=%b fc=%0d, need 0 0 1 0",
               buf_sel, pending, irq_n, frame); n_bad++;
    end
    n_cmp++;
    if ({s_hblank, s_vblank, s_hsync, s_vsync} !== 4'b0001) begin
      $display("FAIL reset_small_sync: got %b, need 0001", {s_hblank, s_vblank, s_hsync, s_vsync}); n_bad++;
    end
    rst = 1'b0;
    s_rst = 1'b0;
    k_sm = 0;
  endtask

  task automatic test_hline();
    int c, r;
    logic ehs;
    for (int k = 1; k <= 800; k++) begin
      tick(1);
      c = k % 800;
      r = k / 800;
      ehs = !((c >= 656) && (c <= 751));
      n_cmp++;
      if ({col, row, hblank, vblank, hsync, vsync} !== {10'(c), 10'(r), (c >= 640), 1'b0, ehs, 1'b1}) begin
        $display("FAIL hline k=%0d: got col=%0d row=%0d hb=%b vb=%b hs=%b vs=%b, need col=%0d row=%0d hb=%b hs=%b",
                 k, col, row, hblank, vblank, hsync, vsync, c, r, (c >= 640), ehs); n_bad++;
      end
    end
  endtask

  task automatic test_pixel_addr();
    tick(3 * 800 + 8);
    n_cmp++;
    if ({col, row, addr, hblank} !== {10'd8, 10'd4, 15'h0102, 1'b0}) begin
      $display("FAIL addr_8_4: got col=%0d row=%0d addr=%h hb=%b, need 8 4 0102 0", col, row, addr, hblank); n_bad++;
    end
    tick(631);
    n_cmp++;
    if ({col, addr} !== {10'd639, 15'h019F}) begin
      $display("FAIL addr_639_4: got col=%0d addr=%h, need 639 019f", col, addr); n_bad++;
    end
    tick(1);
    n_cmp++;
    if ({col, addr, hblank} !== {10'd640, 15'h0000, 1'b1}) begin
      $display("FAIL addr_640_4: got col=%0d addr=%h hb=%b, need 640 0000 1", col, addr, hblank); n_bad++;
    end
  endtask

  task automatic test_enable_freeze();
    tick(60);
    en = 1'b0;
    swap = 1'b1;
    tick(1);
    swap = 1'b0;
    for (int i = 1; i < 100; i++) begin
      n_cmp++;
      if ({col, row, hsync, hblank} !== {10'd700, 10'd4, 1'b0, 1'b1}) begin
        $display("FAIL freeze i=%0d: got col=%0d row=%0d hs=%b hb=%b, need 700 4 0 1", i, col, row, hsync, hblank); n_bad++;
      end
      tick(1);
    end
    n_cmp++;
    if ({pending, buf_sel} !== 2'b10) begin
      $display("FAIL freeze_swap: got pend=%b buf=%b, need 1 0", pending, buf_sel); n_bad++;
    end
    en = 1'b1;
    tick(1);
    n_cmp++;
    if ({col, row} !== {10'd701, 10'd4}) begin
      $display("FAIL resume: got col=%0d row=%0d, need 701 4", col, row); n_bad++;
    end
    tick(51);
    n_cmp++;
    if ({col, hsync} !== {10'd752, 1'b1}) begin
      $display("FAIL resume_hsync_end: got col=%0d hs=%b, need 752 1", col, hsync); n_bad++;
    end
  endtask

  task automatic test_reset_midframe();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({col, row, hblank, vblank, hsync, vsync, addr, buf_sel, pending, frame} !==
        {10'd0, 10'd0, 4'b0011, 15'd0, 2'b00, 8'd0}) begin
      $display("FAIL async_reset: got col=%0d row=%0d hb=%b hs=%b addr=%h pend=%b",
               col, row, hblank, hsync, addr, pending); n_bad++;
    end
    tick(2);
    rst = 1'b0;
    tick(1);
    n_cmp++;
    if ({col, row} !== {10'd1, 10'd0}) begin
      $display("FAIL restart: got col=%0d row=%0d, need 1 0", col, row); n_bad++;
    end
  endtask

  task automatic test_small_frames();
    int c, r, ef;
    logic [1:0] ea;
    s_irq_en = 1'b0;
    sm_reset();
    for (int k = 1; k <= 192; k++) begin
      tick(1);
      c  = k % 12;
      r  = (k / 12) % 8;
      ea = ((c < 4) && (r < 4)) ? {r[1], c[1]} : 2'b00;
      ef = (k >= 48 ? 1 : 0) + (k >= 144 ? 1 : 0);
      n_cmp++;
      if ({s_col, s_row, s_hblank, s_vblank, s_hsync, s_vsync, s_addr, s_frame, s_irq_n} !==
          {4'(c), 3'(r), (c >= 4), (r >= 4), ((c >= 6) && (c <= 9)), !((r == 5) || (r == 6)), ea, 8'(ef), 1'b1}) begin
        $display("FAIL small_frame k=%0d: got col=%0d row=%0d hb=%b vb=%b hs=%b vs=%b addr=%0d fc=%0d irq_n=%b, need col=%0d row=%0d addr=%0d fc=%0d",
                 k, s_col, s_row, s_hblank, s_vblank, s_hsync, s_vsync, s_addr, s_frame, s_irq_n, c, r, ea, ef); n_bad++;
      end
    end
    s_irq_en = 1'b1;
    #1;
    n_cmp++;
    if (s_irq_n !== 1'b0) begin
      $display("FAIL irq_late_enable: got irq_n=%b, need 0", s_irq_n); n_bad++;
    end
    s_ack = 1'b1;
    tick(1);
    s_ack = 1'b0;
    n_cmp++;
    if (s_irq_n !== 1'b1) begin
      $display("FAIL irq_ack_after_enable: got irq_n=%b, need 1", s_irq_n); n_bad++;
    end
    s_irq_en = 1'b0;
  endtask

  task automatic test_swap();
    sm_reset();
    tick(14);
    s_swap = 1'b1;
    tick(1);
    s_swap = 1'b0;
    n_cmp++;
    if ({s_pending, s_buf_sel} !== 2'b10) begin
      $display("FAIL swap_req: got pend=%b buf=%b, need 1 0", s_pending, s_buf_sel); n_bad++;
    end
    tick(32);
    n_cmp++;
    if ({s_pending, s_buf_sel} !== 2'b10) begin
      $display("FAIL swap_before_ve: got pend=%b buf=%b, need 1 0", s_pending, s_buf_sel); n_bad++;
    end
    tick(1);
    n_cmp++;
    if ({s_pending, s_buf_sel} !== 2'b01) begin
      $display("FAIL swap_at_ve: got pend=%b buf=%b, need 0 1", s_pending, s_buf_sel); n_bad++;
    end
    tick(95);
    s_swap = 1'b1;
    tick(1);
    s_swap = 1'b0;
    n_cmp++;
    if ({s_pending, s_buf_sel} !== 2'b00) begin
      $display("FAIL swap_on_ve_edge: got pend=%b buf=%b, need 0 0", s_pending, s_buf_sel); n_bad++;
    end
    tick(6);
    s_swap = 1'b1;
    tick(1);
    s_swap = 1'b0;
    tick(9);
    s_swap = 1'b1;
    tick(1);
    s_swap = 1'b0;
    n_cmp++;
    if ({s_pending, s_buf_sel} !== 2'b10) begin
      $display("FAIL double_swap_pending: got pend=%b buf=%b, need 1 0", s_pending, s_buf_sel); n_bad++;
    end
    tick(79);
    n_cmp++;
    if ({s_pending, s_buf_sel} !== 2'b01) begin
      $display("FAIL double_swap_ve: got pend=%b buf=%b, need 0 1", s_pending, s_buf_sel); n_bad++;
    end
    tick(96);
    n_cmp++;
    if ({s_pending, s_buf_sel, s_frame} !== {2'b01, 8'd4}) begin
      $display("FAIL no_extra_toggle: got pend=%b buf=%b fc=%0d, need 0 1 4", s_pending, s_buf_sel, s_frame); n_bad++;
    end
  endtask

  task automatic test_irq();
    sm_reset();
    s_irq_en = 1'b1;
    tick(47);
    n_cmp++;
    if (s_irq_n !== 1'b1) begin
      $display("FAIL irq_before_ve: got irq_n=%b, need 1", s_irq_n); n_bad++;
    end
    tick(1);
    n_cmp++;
    if (s_irq_n !== 1'b0) begin
      $display("FAIL irq_at_ve: got irq_n=%b, need 0", s_irq_n); n_bad++;
    end
    tick(10);
    n_cmp++;
    if (s_irq_n !== 1'b0) begin
      $display("FAIL irq_sticky: got irq_n=%b, need 0", s_irq_n); n_bad++;
    end
    s_ack = 1'b1;
    tick(1);
    s_ack = 1'b0;
    n_cmp++;
    if (s_irq_n !== 1'b1) begin
      $display("FAIL irq_ack: got irq_n=%b, need 1", s_irq_n); n_bad++;
    end
    tick(84);
    s_ack = 1'b1;
    tick(1);
    s_ack = 1'b0;
    n_cmp++;
    if (s_irq_n !== 1'b0) begin
      $display("FAIL irq_ack_on_ve: got irq_n=%b, need 0", s_irq_n); n_bad++;
    end
    tick(1);
    n_cmp++;
    if (s_irq_n !== 1'b0) begin
      $display("FAIL irq_hold_after_ve: got irq_n=%b, need 0", s_irq_n); n_bad++;
    end
    s_irq_en = 1'b0;
    #1;
    n_cmp++;
    if (s_irq_n !== 1'b1) begin
      $display("FAIL irq_mask: got irq_n=%b, need 1", s_irq_n); n_bad++;
    end
  endtask

  initial begin
    test_reset();
    test_hline();
    test_pixel_addr();
    test_enable_freeze();
    test_reset_midframe();
    test_small_frames();
    test_swap();
    test_irq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
